seg_scan_disp: RTL and testbench

//  Multiplexed 8-digit 7-segment scan driver sitting downstream of the time-of-day

---
 rtl/seg_scan_disp_if.sv | 12 +
 rtl/seg_scan_disp.sv | 104 ++++++++++
 tb/tb_seg_scan_disp.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/seg_scan_disp_if.sv
// Display bus between the time-of-day counter and the 7-segment scan driver.
// The master supplies packed digits, blink and decimal-point masks; the slave drives the pins.
interface seg_scan_disp_if;
  logic [31:0] din;
  logic [7:0]  blink;
  logic [7:0]  dp;
  logic [7:0]  seg;
  logic [7:0]  sel;

  modport master (output din, blink, dp, input seg, sel);
  modport slave  (input din, blink, dp, output seg, sel);
endinterface

// File: rtl/seg_scan_disp.sv
// Multiplexed 8-digit 7-segment scan driver with per-digit blink and decimal point.
// The inputs are captured into a shadow copy once per frame, so a frame never tears.
module seg_scan_disp #(
  parameter int unsigned SCAN_CNT    = 50_000,
  parameter int unsigned BLINK_CNT   = 25_000_000,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          SEL_ACT_LOW = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_scan_disp_if.slave disp
);

  localparam int unsigned SCAN_W  = $clog2(SCAN_CNT);
  localparam int unsigned BLINK_W = $clog2(BLINK_CNT);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_CNT - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CNT - 1);
  localparam logic [7:0] SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0] SEL_OFF = SEL_ACT_LOW ? 8'hFF : 8'h00;

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_on_q, blink_on_d;
  logic [31:0]        shadow_din_q, shadow_din_d;
  logic [7:0]         shadow_blink_q, shadow_blink_d;
  logic [7:0]         shadow_dp_q, shadow_dp_d;
  logic [7:0]         seg_q, seg_d;
  logic [7:0]         sel_q, sel_d;

  logic       scan_wrap;
  logic       frame_wrap;
  logic       blink_wrap;
  logic [3:0] nibble;
  logic [6:0] glyph;
  logic [7:0] pattern;

  always_comb begin
    scan_wrap      = (scan_cnt_q == SCAN_LAST);
    frame_wrap     = scan_wrap && (idx_q == 3'd7);
    blink_wrap     = (blink_cnt_q == BLINK_LAST);
    scan_cnt_d     = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
    idx_d          = scan_wrap ? idx_q + 3'd1 : idx_q;
    blink_cnt_d    = blink_wrap ? '0 : blink_cnt_q + BLINK_W'(1);
    blink_on_d     = blink_wrap ? ~blink_on_q : blink_on_q;
    shadow_din_d   = frame_wrap ? disp.din   : shadow_din_q;
    shadow_blink_d = frame_wrap ? disp.blink : shadow_blink_q;
    shadow_dp_d    = frame_wrap ? disp.dp    : shadow_dp_q;
  end

  // Pins are computed from the current digit index and shadow, then registered
  // together, so seg and sel always switch on the same edge.
  always_comb begin
    nibble = shadow_din_q[{idx_q, 2'b00} +: 4];
    case (nibble)
      4'h0:    glyph = 7'h3F;
      4'h1:    glyph = 7'h06;
      4'h2:    glyph = 7'h5B;
      4'h3:    glyph = 7'h4F;
      4'h4:    glyph = 7'h66;
      4'h5:    glyph = 7'h6D;
      4'h6:    glyph = 7'h7D;
      4'h7:    glyph = 7'h07;
      4'h8:    glyph = 7'h7F;
      4'h9:    glyph = 7'h6F;
      4'hA:    glyph = 7'h40;
      default: glyph = 7'h00;
    endcase
    pattern = {shadow_dp_q[idx_q], glyph};
    if (shadow_blink_q[idx_q] && !blink_on_q) begin
      pattern = 8'h00;
    end
    seg_d = SEG_ACT_LOW ? ~pattern : pattern;
    sel_d = (8'd1 << idx_q) ^ SEL_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q     <= '0;
      idx_q          <= 3'd0;
      blink_cnt_q    <= '0;
      blink_on_q     <= 1'b1;
      shadow_din_q   <= 32'h0;
      shadow_blink_q <= 8'h00;
      shadow_dp_q    <= 8'h00;
      seg_q          <= SEG_OFF;
      sel_q          <= SEL_OFF;
    end else begin
      scan_cnt_q     <= scan_cnt_d;
      idx_q          <= idx_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_on_q     <= blink_on_d;
      shadow_din_q   <= shadow_din_d;
      shadow_blink_q <= shadow_blink_d;
      shadow_dp_q    <= shadow_dp_d;
      seg_q          <= seg_d;
      sel_q          <= sel_d;
    end
  end

  assign disp.seg = seg_q;
  assign disp.sel = sel_q;

endmodule

// File: tb/tb_seg_scan_disp.sv
// Directed bench for seg_scan_disp (SCAN_CNT=4, BLINK_CNT=64, active-low pins).
// k counts clock edges since the last reset release; outputs are sampled 1 time unit after each edge.
module tb_seg_scan_disp;

  logic clk = 1'b0;
  logic rst_n;
  logic postEdge;
  int   k = 0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] segTab [16];
  logic [7:0] oldTab [8];

  seg_scan_disp_if dispIf ();

  seg_scan_disp #(
    .SCAN_CNT   (4),
    .BLINK_CNT  (64),
    .SEG_ACT_LOW(1'b1),
    .SEL_ACT_LOW(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .disp (dispIf)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) postEdge <= 1'b0;
    else        postEdge <= 1'b1;
  end

  // sel must be exactly one low bit whenever the driver is running
  always @(negedge clk) begin
    if (rst_n === 1'b1 && postEdge === 1'b1) begin
      checks++;
      assert ($onehot(~dispIf.sel) === 1'b1) else begin
        errors++;
        $error("FAIL oneHotSel observed=%h expected=one-hot-low", dispIf.sel);
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] din, input logic [7:0] blink, input logic [7:0] dp);
    dispIf.din   = din;
    dispIf.blink = blink;
    dispIf.dp    = dp;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    k += n;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic int digitOf(input int kk);
    return ((kk - 1) / 4) % 8;
  endfunction

  function automatic logic [7:0] expSel(input int kk);
    logic [7:0] one;
    one = 8'd1;
    return ~(one << digitOf(kk));
  endfunction

  task automatic checkPins(input string tag, input logic [7:0] expSeg);
    checkOutput($sformatf("%s_sel_k%0d", tag, k), dispIf.sel, expSel(k));
    checkOutput($sformatf("%s_seg_k%0d", tag, k), dispIf.seg, expSeg);
  endtask

  initial begin
    segTab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
               8'h80, 8'h90, 8'hBF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    oldTab = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80};

    rst_n = 1'b0;
    applyStimulus(32'h12A34A56, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetSeg", dispIf.seg, 8'hFF);
    checkOutput("resetSel", dispIf.sel, 8'hFF);

    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    $display("[TB] reset released");

    // Frame 0: shadow still zero, every digit shows '0' for 4 clocks
    while (k < 32) begin
      tick(1);
      checkPins("frame0", 8'hC0);
    end

    // Frame 1 shows 12A34A56
    while (k < 64) begin
      logic [7:0] f1 [8];
      f1 = '{8'h82, 8'h92, 8'hBF, 8'h99, 8'hB0, 8'hBF, 8'hA4, 8'hF9};
      tick(1);
      checkPins("frame1", f1[digitOf(k)]);
    end

    // Nibble sweep on digit 0, one value every two frames
    for (int n = 0; n < 16; n++) begin
      applyStimulus({28'h0, 4'(n)}, 8'h00, 8'h00);
      tick(33);
      checkPins($sformatf("sweep%0d", n), segTab[n]);
      tick(31);
    end

    // Mid-frame change must not appear until the next frame
    applyStimulus(32'h87654321, 8'h00, 8'h00);
    tick(32);
    tick(13);
    checkOutput("midFrameIdx3", dispIf.sel, 8'hF7);
    applyStimulus(32'h99999999, 8'h00, 8'h00);
    checkPins("midFrameNow", oldTab[3]);
    while (k < 1184) begin
      tick(1);
      if (k <= 1152) checkPins("midFrameOld", oldTab[digitOf(k)]);
      else           checkPins("midFrameNew", 8'h90);
    end

    // Blink on digits 0 and 1, 64-clock half-period
    applyStimulus(32'h00000099, 8'h03, 8'h00);
    tick(32);
    while (k < 1472) begin
      tick(1);
      if (digitOf(k) < 2) checkPins("blink", (((k - 1) / 64) % 2 == 0) ? 8'h90 : 8'hFF);
      else                checkPins("blinkOther", 8'hC0);
    end

    // Decimal point on digit 4 only
    applyStimulus(32'h00000099, 8'h00, 8'h10);
    tick(32);
    while (k < 1536) begin
      tick(1);
      if (digitOf(k) < 2)       checkPins("dpNine", 8'h90);
      else if (digitOf(k) == 4) checkPins("dpLit", 8'h40);
      else                      checkPins("dpOff", 8'hC0);
    end

    // Asynchronous reset in the middle of a scan
    tick(9);
    checkPins("preReset", 8'hC0);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncResetSeg", dispIf.seg, 8'hFF);
    checkOutput("asyncResetSel", dispIf.sel, 8'hFF);
    @(posedge clk);
    #1;
    checkOutput("heldResetSeg", dispIf.seg, 8'hFF);
    checkOutput("heldResetSel", dispIf.sel, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (k < 8) begin
      tick(1);
      checkPins("restart", 8'hC0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
